serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder.sv | 115 +++++++++++
 tb/tb_serial_adder.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder step per clock, LSB first.
// The full adder is built from two half adders and an OR of their carries.
// result is only meaningful while done is high and afterwards until the next accepted start.

module half_adder (
   input  logic i_x,
   input  logic i_y,
   output logic o_s,
   output logic o_c
);
   assign o_s = i_x ^ i_y;
   assign o_c = i_x & i_y;
endmodule

module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic [WIDTH:0]   result
);
   // The counter must be able to hold WIDTH without wrapping.
   localparam int CW = $clog2(WIDTH + 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SHIFT = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

   logic [1:0]       r_state;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_sum;
   logic             r_carry;
   logic [CW-1:0]    r_cnt;

   logic w_s1;
   logic w_c1;
   logic w_s2;
   logic w_c2;
   logic w_fa_carry;

   // First half adder combines the two operand bits.
   half_adder u_ha0 (
      .i_x (r_a[0]),
      .i_y (r_b[0]),
      .o_s (w_s1),
      .o_c (w_c1)
   );

   // Second half adder folds in the carry from the previous bit.
   half_adder u_ha1 (
      .i_x (w_s1),
      .i_y (r_carry),
      .o_s (w_s2),
      .o_c (w_c2)
   );

   // At most one of the two half-adder carries can be set, so OR is the full-adder carry.
   assign w_fa_carry = w_c1 | w_c2;

   // FSM and datapath: load on accepted start, one bit per SHIFT edge, single-cycle DONE.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_a     <= '0;
         r_b     <= '0;
         r_sum   <= '0;
         r_carry <= 1'b0;
         r_cnt   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_a     <= a;
                  r_b     <= b;
                  r_sum   <= '0;
                  r_carry <= 1'b0;
                  r_cnt   <= '0;
                  r_state <= S_SHIFT;
               end
            end
            S_SHIFT: begin
               // Sum bits enter from the top so the first (LSB) sum ends up in bit 0.
               r_a     <= r_a >> 1;
               r_b     <= r_b >> 1;
               r_sum   <= {w_s2, r_sum[WIDTH-1:1]};
               r_carry <= w_fa_carry;
               r_cnt   <= r_cnt + 1'b1;
               if (r_cnt == CW'(WIDTH - 1)) begin
                  r_state <= S_DONE;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign ready  = (r_state == S_IDLE);
   assign busy   = (r_state == S_SHIFT) || (r_state == S_DONE);
   assign done   = (r_state == S_DONE);
   // The carry flop ends the operation holding the final carry out, which becomes the MSB.
   assign result = {r_carry, r_sum};

endmodule

// File: tb/tb_serial_adder.sv
// Randomized and directed checks of serial_adder against a plain-arithmetic reference.

module tb_serial_adder;
   localparam int WIDTH = 8;

   logic             clk;
   logic             rst;
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             ready;
   logic             busy;
   logic             done;
   logic [WIDTH:0]   result;

   int n_checks;
   int n_errors;
   int cyc;
   int last_acc;
   int prev_acc;

   serial_adder #(.WIDTH(WIDTH)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .a      (a),
      .b      (b),
      .ready  (ready),
      .busy   (busy),
      .done   (done),
      .result (result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Free-running edge counter used to measure spacing between acceptances.
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: the sum of the two operands, carry included.
   function automatic logic [31:0] ref_sum(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
      return 32'(x) + 32'(y);
   endfunction

   // Issue one operation at the current negedge and follow it until IDLE returns.
   // With mid set, a second start with other operands is pulsed during SHIFT.
   task automatic run_op(input string tag, input logic [WIDTH-1:0] xa,
                         input logic [WIDTH-1:0] xb, input bit mid);
      int busy_cnt;
      int done_cnt;
      int done_at;
      int idle_at;
      logic [WIDTH:0] res;
      logic [31:0] exp;
      exp = ref_sum(xa, xb);
      for (int w = 0; w < 40 && !ready; w++) @(negedge clk);
      check({tag, "_ready_before"}, 32'(ready), 32'd1);
      start = 1'b1;
      a = xa;
      b = xb;
      @(posedge clk);
      prev_acc = last_acc;
      last_acc = cyc;
      busy_cnt = 0;
      done_cnt = 0;
      done_at  = 0;
      idle_at  = 0;
      res      = '0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         start = 1'b0;
         if (mid && k == 3) begin
            start = 1'b1;
            a = 8'h77;
            b = 8'h77;
         end
         if (done) begin
            done_cnt++;
            done_at = k;
            res = result;
            check({tag, "_ready_in_done"}, 32'(ready), 32'd0);
         end
         if (busy) busy_cnt++;
         if (ready) begin
            idle_at = k;
            break;
         end
      end
      check({tag, "_result"}, 32'(res), exp);
      check({tag, "_done_count"}, 32'(done_cnt), 32'd1);
      check({tag, "_done_latency"}, 32'(done_at), 32'(WIDTH + 1));
      check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(WIDTH + 1));
      check({tag, "_idle_at"}, 32'(idle_at), 32'(WIDTH + 2));
      check({tag, "_result_hold"}, 32'(result), exp);
      $display("op %s: a=0x%02h b=0x%02h result=0x%03h expected=0x%03h", tag, xa, xb, res, exp[WIDTH:0]);
   endtask

   initial begin
      logic [WIDTH-1:0] ra;
      logic [WIDTH-1:0] rb;
      int done_seen;
      n_checks = 0;
      n_errors = 0;
      cyc = 0;
      last_acc = 0;
      prev_acc = 0;
      rst = 1'b1;
      start = 1'b0;
      a = '0;
      b = '0;
      repeat (3) @(negedge clk);
      check("reset_ready", 32'(ready), 32'd1);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_done", 32'(done), 32'd0);
      check("reset_result", 32'(result), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Zero plus zero.
      run_op("zero", 8'h00, 8'h00, 1'b0);
      // Full carry out.
      run_op("ff_01", 8'hFF, 8'h01, 1'b0);

      // Back-to-back: second start in the first IDLE cycle after done.
      run_op("a5_5a", 8'hA5, 8'h5A, 1'b0);
      run_op("ff_ff", 8'hFF, 8'hFF, 1'b0);
      check("issue_interval", 32'(last_acc - prev_acc), 32'(WIDTH + 2));

      // Start during SHIFT must be ignored.
      run_op("ignore_mid", 8'h12, 8'h34, 1'b1);

      // Reset on the 4th SHIFT edge discards the operation.
      start = 1'b1;
      a = 8'h0F;
      b = 8'h0F;
      @(posedge clk);
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         start = 1'b0;
      end
      rst = 1'b1;
      @(negedge clk);
      check("midrst_ready", 32'(ready), 32'd1);
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_result", 32'(result), 32'd0);
      rst = 1'b0;
      done_seen = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (done) done_seen++;
      end
      check("midrst_no_done", 32'(done_seen), 32'd0);
      $display("op midrst: a=0x0f b=0x0f reset on 4th shift edge, done pulses=%0d", done_seen);

      // Reset and start at the same edge: reset wins.
      rst = 1'b1;
      start = 1'b1;
      a = 8'h33;
      b = 8'h44;
      @(negedge clk);
      check("rst_start_ready", 32'(ready), 32'd1);
      check("rst_start_busy", 32'(busy), 32'd0);
      rst = 1'b0;
      start = 1'b0;
      @(negedge clk);
      check("rst_start_idle", 32'(ready), 32'd1);
      run_op("after_rst", 8'h33, 8'h44, 1'b0);

      // Random operands.
      for (int i = 0; i < 16; i++) begin
         ra = WIDTH'($urandom);
         rb = WIDTH'($urandom);
         run_op($sformatf("rand%0d", i), ra, rb, 1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
